// File: rtl/dmem_port_arbiter_if.sv
// Data-memory port bundle shared by the CPU, the loader and the memory.
// The arbiter takes the slave side; whatever drives requests takes master.
interface dmem_port_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_stall;
    logic        ld_req;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_gnt;
    logic [31:0] rdata;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        err;
    logic [15:0] stall_cnt;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ld_req, ld_we, ld_addr, ld_wdata,
        output mem_rdata,
        input  cpu_stall, ld_gnt, rdata,
        input  mem_we, mem_addr, mem_wdata,
        input  err, stall_cnt
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        input  mem_rdata,
        output cpu_stall, ld_gnt, rdata,
        output mem_we, mem_addr, mem_wdata,
        output err, stall_cnt
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter with bounded bursts for the data-memory port,
// shared between the CPU load/store path and a loader/debug master.
module dmem_port_arbiter #(
    parameter int MAX_BURST  = 4,
    parameter int ADDR_LIMIT = 256
) (
    input logic               clk,
    input logic               rst,
    dmem_port_arbiter_if.slave bus
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

    logic          owner;
    logic [BW-1:0] burst;
    logic          err_q;
    logic [15:0]   cnt_q;

    logic          win_ld;
    logic          cpu_gnt;
    logic          ld_gnt;
    logic          any_gnt;
    logic          gnt_we;
    logic          illegal;
    logic [31:0]   addr;
    logic [31:0]   wdata;

    always_comb begin
        // Under contention the owner keeps the port until its burst is used up.
        if (bus.cpu_req && bus.ld_req)
            win_ld = (burst == BMAX) ? ~owner : owner;
        else
            win_ld = bus.ld_req;
        ld_gnt  = ~rst & bus.ld_req & win_ld;
        cpu_gnt = ~rst & bus.cpu_req & ~win_ld;
        any_gnt = cpu_gnt | ld_gnt;
        addr    = ld_gnt ? bus.ld_addr : bus.cpu_addr;
        wdata   = ld_gnt ? bus.ld_wdata : bus.cpu_wdata;
        gnt_we  = ld_gnt ? bus.ld_we : (cpu_gnt & bus.cpu_we);
        illegal = any_gnt &
                  ((addr[1:0] != 2'b00) || (addr >= 32'(ADDR_LIMIT)));
    end

    assign bus.ld_gnt    = ld_gnt;
    assign bus.cpu_stall = ~rst & bus.cpu_req & ~cpu_gnt;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = wdata;
    assign bus.mem_we    = gnt_we & ~illegal;
    assign bus.rdata     = bus.mem_rdata;
    assign bus.err       = err_q;
    assign bus.stall_cnt = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            owner <= 1'b0;
            burst <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (any_gnt) begin
                if (ld_gnt == owner) begin
                    if (burst != BMAX)
                        burst <= burst + 1'b1;
                end else begin
                    owner <= ld_gnt;
                    burst <= BW'(1);
                end
            end else begin
                burst <= '0;
            end
            err_q <= illegal;
            if (bus.cpu_stall && (cnt_q != 16'hFFFF))
                cnt_q <= cnt_q + 16'd1;
        end
    end
endmodule
